// File: rtl/dma_wr_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dma_wr_job_sched                                              |
// | Purpose  : Round-robin scheduler sharing one DMA write-command engine    |
// |            between NUM_CH channels; counts AXI B beats per job and       |
// |            pulses a per-channel done. DMA_WR_SCHED_BRESP_CHK_EN adds     |
// |            the err output for jobs that saw a non-OKAY B response.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dma_wr_job_sched #(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*SIZE_WIDTH-1:0] req_size,
    output logic [NUM_CH-1:0]            done,
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
    output logic [NUM_CH-1:0]            err,
`endif
    output logic                         eng_start,
    output logic [ID_WIDTH-1:0]          eng_dst_id,
    output logic [ADDR_WIDTH-1:0]        eng_dst_addr,
    output logic [SIZE_WIDTH-1:0]        eng_size,
    input  logic                         bvalid,
    input  logic                         bready,
    input  logic [ID_WIDTH-1:0]          bid,
    input  logic [1:0]                   bresp,
    output logic                         busy
);

    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_BL_W = SIZE_WIDTH - 7;
    localparam logic [c_BL_W-1:0] c_BURST_ONE = c_BL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CH_W-1:0]       r_rr_ptr;
    logic [c_CH_W-1:0]       r_ch;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [SIZE_WIDTH-1:0]   r_size;
    logic [c_BL_W-1:0]       r_bursts_left;
    logic [c_CH_W-1:0]       w_gnt_idx;
    logic [c_CH_W-1:0]       w_cand;
    logic                    w_found;
    logic                    w_idle;
    logic                    w_accept;
    logic                    w_b_hit;
    logic [SIZE_WIDTH-1:0]   w_sel_size;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
    logic                    r_job_err;
`else
    logic                    w_unused_bresp;
    assign w_unused_bresp = ^bresp;
`endif

    // First valid channel at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = c_CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_accept   = w_idle && w_found;
    assign req_ready  = w_accept ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign w_sel_size = req_size[w_gnt_idx*SIZE_WIDTH +: SIZE_WIDTH];
    assign w_b_hit    = bvalid && bready && (bid == ID_WIDTH'(r_ch));

    assign eng_dst_id   = ID_WIDTH'(r_ch);
    assign eng_dst_addr = r_addr;
    assign eng_size     = r_size;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        eng_start   = 1'b0;
        done        = '0;
        busy        = (r_state != ST_IDLE);
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
        err         = '0;
`endif
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
            ST_START: begin
                eng_start   = 1'b1;
                w_state_nxt = ST_WAIT_B;
            end
            ST_WAIT_B: if (w_b_hit && (r_bursts_left == c_BURST_ONE)) w_state_nxt = ST_DONE;
            ST_DONE: begin
                done        = NUM_CH'(1) << r_ch;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
                err         = r_job_err ? (NUM_CH'(1) << r_ch) : '0;
`endif
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_ch          <= '0;
            r_addr        <= '0;
            r_size        <= '0;
            r_bursts_left <= '0;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
            r_job_err     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_ch          <= w_gnt_idx;
                r_addr        <= req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_size        <= w_sel_size;
                // One AXI burst per 256 beats.
                r_bursts_left <= {1'b0, w_sel_size[SIZE_WIDTH-1:8]} + c_BURST_ONE;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
                r_job_err     <= 1'b0;
`endif
            end
            if ((r_state == ST_WAIT_B) && w_b_hit) begin
                r_bursts_left <= r_bursts_left - c_BURST_ONE;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
                if (bresp != 2'b00) r_job_err <= 1'b1;
`endif
            end
            if (r_state == ST_DONE) r_rr_ptr <= c_CH_W'((int'(r_ch) + 1) % NUM_CH);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_wr_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dma_wr_job_sched                                           |
// | Purpose  : Self-checking bench for dma_wr_job_sched against a job-level  |
// |            reference model; directed scenarios plus random traffic.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dma_wr_job_sched;
    localparam int NUM_CH = 4, ID_WIDTH = 4, ADDR_WIDTH = 32, SIZE_WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0]            req_valid, req_ready, done;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*SIZE_WIDTH-1:0] req_size;
    logic                         eng_start, bvalid, bready, busy;
    logic [ID_WIDTH-1:0]          eng_dst_id, bid;
    logic [ADDR_WIDTH-1:0]        eng_dst_addr;
    logic [SIZE_WIDTH-1:0]        eng_size;
    logic [1:0]                   bresp;
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
    logic [NUM_CH-1:0]            err;
`endif

    always #5 clk = ~clk;

    dma_wr_job_sched #(.NUM_CH(NUM_CH), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                       .SIZE_WIDTH(SIZE_WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .done(done),
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
        .err(err),
`endif
        .eng_start(eng_start), .eng_dst_id(eng_dst_id), .eng_dst_addr(eng_dst_addr),
        .eng_size(eng_size), .bvalid(bvalid), .bready(bready), .bid(bid),
        .bresp(bresp), .busy(busy)
    );

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    // Job-level model: a job is accepted, launched one cycle later, then
    // counts matching B beats after launch; done is the cycle after the last.
    bit                    m_active = 0, m_fin = 0, m_err = 0;
    int                    m_age = 0, m_left = 0, m_ch = 0, m_rr = 0;
    logic [ADDR_WIDTH-1:0] m_addr = '0;
    logic [SIZE_WIDTH-1:0] m_size = '0;
    int                    d_order[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_pick(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_rr + i) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int c;
        if (rst) begin
            m_active = 0; m_fin = 0; m_err = 0; m_age = 0; m_left = 0;
            m_ch = 0; m_rr = 0; m_addr = '0; m_size = '0;
        end else if (m_fin) begin
            m_active = 0; m_fin = 0; m_rr = (m_ch + 1) % NUM_CH;
        end else if (m_active) begin
            if (m_age >= 2 && bvalid && bready && int'(bid) == m_ch) begin
                m_left--;
                if (bresp != 2'b00) m_err = 1;
                if (m_left == 0) m_fin = 1;
            end
            m_age++;
        end else begin
            c = m_pick(req_valid);
            if (c >= 0) begin
                m_active = 1; m_age = 1; m_ch = c; m_err = 0;
                m_addr = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                m_size = req_size[c*SIZE_WIDTH +: SIZE_WIDTH];
                m_left = int'(m_size[SIZE_WIDTH-1:8]) + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst)
            for (int i = 0; i < NUM_CH; i++)
                if (req_valid[i] && req_ready[i]) d_order.push_back(i);
        model_step();
        #1;
    endtask

    task automatic set_req(input int ch, input logic [31:0] a, input logic [15:0] s);
        req_valid[ch] = 1'b1;
        req_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_size[ch*SIZE_WIDTH +: SIZE_WIDTH] = s;
    endtask

    task automatic b_beat(input int id, input logic [1:0] resp);
        bvalid = 1'b1; bready = 1'b1; bid = ID_WIDTH'(id); bresp = resp;
        tick();
        bvalid = 1'b0; bready = 1'b0; bresp = 2'b00;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            logic [NUM_CH-1:0] e_ready, e_onehot;
            c        = m_pick(req_valid);
            e_ready  = (!m_active && !rst && c >= 0) ? (NUM_CH'(1) << c) : '0;
            e_onehot = NUM_CH'(1) << m_ch;
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("busy", 64'(busy), 64'(m_active));
            check("eng_start", 64'(eng_start), 64'(m_active && !m_fin && m_age == 1));
            check("done", 64'(done), 64'(m_fin ? e_onehot : '0));
            check("eng_dst_id", 64'(eng_dst_id), 64'(m_ch));
            check("eng_dst_addr", 64'(eng_dst_addr), 64'(m_addr));
            check("eng_size", 64'(eng_size), 64'(m_size));
`ifdef DMA_WR_SCHED_BRESP_CHK_EN
            check("err", 64'(err), 64'((m_fin && m_err) ? e_onehot : '0));
`endif
        end
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '1; req_addr = '0; req_size = '0;
        bvalid = 1'b0; bready = 1'b0; bid = '0; bresp = 2'b00;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_addr", 64'(eng_dst_addr), 64'd0);
        tick();
        req_valid = '0; rst = 1'b0;

        // Single-burst job on channel 0.
        set_req(0, 32'h1000, 16'h00FF);
        @(negedge clk); check("single_grant", 64'(req_ready), 64'h1);
        tick(); req_valid = '0;
        @(negedge clk);
        check("single_start", 64'(eng_start), 64'd1);
        check("single_id", 64'(eng_dst_id), 64'd0);
        check("single_addr", 64'(eng_dst_addr), 64'h1000);
        tick();
        b_beat(0, 2'b00);
        @(negedge clk); check("single_done", 64'(done), 64'h1);
        tick();

        // Three-burst job on channel 2 with a foreign-ID beat in between.
        set_req(2, 32'h2000, 16'h02FF);
        tick(); req_valid = '0; tick();
        b_beat(2, 2'b00); b_beat(1, 2'b00); b_beat(2, 2'b00);
        @(negedge clk); check("multi_no_early", 64'(done), 64'h0);
        b_beat(2, 2'b00);
        @(negedge clk); check("multi_done", 64'(done), 64'h4);
        tick();

        // Channel 1 raises valid mid-job and must wait for IDLE.
        set_req(0, 32'h3000, 16'h0000);
        tick(); req_valid = '0; tick();
        set_req(1, 32'h4000, 16'h0000);
        @(negedge clk); check("hold_wait", 64'(req_ready), 64'h0);
        b_beat(0, 2'b00);
        @(negedge clk); check("hold_done", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk); check("hold_idle", 64'(req_ready), 64'h2);
        tick(); req_valid = '0; tick();
        b_beat(1, 2'b00); tick();

        // Reset in the middle of a three-burst job.
        set_req(3, 32'h5000, 16'h02FF);
        tick(); req_valid = '0; tick();
        b_beat(3, 2'b00);
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_addr", 64'(eng_dst_addr), 64'd0);
        set_req(3, 32'h5000, 16'h02FF);
        tick(); req_valid = '0; tick();
        b_beat(3, 2'b00); b_beat(3, 2'b00);
        @(negedge clk); check("rstmid_full_count", 64'(done), 64'h0);
        b_beat(3, 2'b00);
        @(negedge clk); check("rstmid_done_after3", 64'(done), 64'h8);
        tick();

`ifdef DMA_WR_SCHED_BRESP_CHK_EN
        set_req(1, 32'h6000, 16'h01FF);
        tick(); req_valid = '0; tick();
        b_beat(1, 2'b00); b_beat(1, 2'b10);
        @(negedge clk);
        check("err_pulse", 64'(err), 64'h2);
        check("err_done", 64'(done), 64'h2);
        tick();
        set_req(1, 32'h7000, 16'h0000);
        tick(); req_valid = '0; tick();
        b_beat(1, 2'b00);
        @(negedge clk); check("err_clean", 64'(err), 64'h0);
        tick();
`endif

        // Round-robin from reset with all channels valid.
        rst = 1'b1; req_valid = '1; req_size = '0; tick(); rst = 1'b0;
        d_order.delete();
        for (int cyc = 0; cyc < 200 && d_order.size() < 5; cyc++) begin
            bvalid = m_active && m_age >= 2; bready = 1'b1; bid = ID_WIDTH'(m_ch);
            tick();
        end
        check("rr_count", 64'(d_order.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            check("rr_order", 64'((k < d_order.size()) ? d_order[k] : -1), 64'(exp_order[k]));
        req_valid = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bvalid = m_active && m_age >= 2; bready = 1'b1; bid = ID_WIDTH'(m_ch);
            tick();
        end

        // Random traffic against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 3) == 0) req_valid = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                req_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = $urandom;
                req_size[c*SIZE_WIDTH +: SIZE_WIDTH] = {8'($urandom_range(0, 2)), 8'($urandom)};
            end
            bvalid = 1'($urandom);
            bready = ($urandom_range(0, 3) != 0);
            bid    = ($urandom_range(0, 1) == 1) ? ID_WIDTH'(m_ch) : ID_WIDTH'($urandom);
            bresp  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            rst    = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; bvalid = 1'b0; req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
